// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and a one-beat prefix mechanism.
// Optional feature macro: IMM_ZEXT_EN (zext=1 selects zero-extension for data beats).
module imm_extend_pipe #(
    parameter int IMM_W  = 23,
    parameter int DATA_W = 32,
    parameter int PFX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  inm,
    input  logic [1:0]        extendSel,
    input  logic              zext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] extendRes,
    output logic              prefix_used,
    output logic              pfx_pending
);

    typedef enum logic {
        S_IDLE,
        S_HELD
    } state_t;

    // Masks selecting the payload bits of the full, mid (>>4) and short (>>8) fields.
    localparam logic [DATA_W-1:0] MASK_FULL  = {DATA_W{1'b1}} >> (DATA_W - IMM_W);
    localparam logic [DATA_W-1:0] MASK_MID   = {DATA_W{1'b1}} >> (DATA_W - IMM_W + 4);
    localparam logic [DATA_W-1:0] MASK_SHORT = {DATA_W{1'b1}} >> (DATA_W - IMM_W + 8);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PFX_W-1:0]    r_prefix;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_ext_res;
    logic                r_prefix_used;

    logic                w_accept;
    logic                w_is_data;
    logic                w_fill;
    logic [DATA_W-1:0]   w_inm_wide;
    logic [DATA_W-1:0]   w_field;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_ext;
    logic [DATA_W-1:0]   w_merged;

    assign in_ready  = !flush && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_data = (extendSel != 2'b00);

`ifdef IMM_ZEXT_EN
    assign w_fill = inm[IMM_W-1] & ~zext;
`else
    // zext is read but has no effect in this build; the OR folds to constant 1.
    assign w_fill = inm[IMM_W-1] & (zext | 1'b1);
`endif

    assign w_inm_wide = DATA_W'(inm);

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        w_field = w_inm_wide;
        w_mask  = MASK_FULL;
        case (extendSel)
            2'b10: begin
                w_field = w_inm_wide >> 4;
                w_mask  = MASK_MID;
            end
            2'b11: begin
                w_field = w_inm_wide >> 8;
                w_mask  = MASK_SHORT;
            end
            default: begin
                w_field = w_inm_wide;
                w_mask  = MASK_FULL;
            end
        endcase
    end

    assign w_ext    = (w_field & w_mask) | (w_fill ? ~w_mask : '0);
    assign w_merged = {r_prefix, w_ext[DATA_W-PFX_W-1:0]};

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_is_data ? S_IDLE : S_HELD;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prefix      <= '0;
            r_out_valid   <= 1'b0;
            r_ext_res     <= '0;
            r_prefix_used <= 1'b0;
        end else if (flush) begin
            // extendRes deliberately keeps its last value across a flush.
            r_out_valid   <= 1'b0;
            r_prefix_used <= 1'b0;
        end else begin
            if (w_accept && w_is_data) begin
                r_out_valid   <= 1'b1;
                r_ext_res     <= (r_state == S_HELD) ? w_merged : w_ext;
                r_prefix_used <= (r_state == S_HELD);
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
            if (w_accept && !w_is_data) begin
                r_prefix <= inm[PFX_W-1:0];
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign extendRes   = r_ext_res;
    assign prefix_used = r_prefix_used;
    assign pfx_pending = (r_state == S_HELD);

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: stimulus pushes expected results, a monitor pops on each transfer.
// Expected values follow the IMM_ZEXT_EN macro when it is defined for the build.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] inm;
    logic [1:0]  extendSel;
    logic        zext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] extendRes;
    logic        prefix_used;
    logic        pfx_pending;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] sb_q[$];

    imm_extend_pipe #(.IMM_W(23), .DATA_W(32), .PFX_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inm        (inm),
        .extendSel  (extendSel),
        .zext       (zext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .extendRes  (extendRes),
        .prefix_used(prefix_used),
        .pfx_pending(pfx_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one transfer per negedge where out_valid && out_ready.
    always @(negedge clk) begin
        logic [32:0] exp;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got %h expected none", extendRes);
            end else begin
                exp = sb_q.pop_front();
                check("result", extendRes, exp[31:0]);
                check("prefix_used", {31'b0, prefix_used}, {31'b0, exp[32]});
            end
        end
    end

    // Drive one beat (called just after a posedge); returns just after the accepting posedge.
    task automatic send(input logic [1:0] sel, input logic [22:0] v, input logic z);
        bit ok = 1'b0;
        in_valid  = 1'b1;
        extendSel = sel;
        inm       = v;
        zext      = z;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; inm = '0;
        extendSel = 2'b00; zext = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_extendRes", extendRes, 32'd0);
        check("rst_prefix_used", {31'b0, prefix_used}, 32'd0);
        check("rst_pfx_pending", {31'b0, pfx_pending}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Field extension, back to back.
        sb_q.push_back({1'b0, 32'hFFC00000});
        send(2'b01, 23'h400000, 1'b0);
`ifdef IMM_ZEXT_EN
        sb_q.push_back({1'b0, 32'h00400000});
`else
        sb_q.push_back({1'b0, 32'hFFC00000});
`endif
        send(2'b01, 23'h400000, 1'b1);
        sb_q.push_back({1'b0, 32'h00001234});
        send(2'b10, 23'h012345, 1'b0);
        sb_q.push_back({1'b0, 32'hFFFFFFFF});
        send(2'b11, 23'h7FFF00, 1'b0);
`ifdef IMM_ZEXT_EN
        sb_q.push_back({1'b0, 32'h00007FFF});
`else
        sb_q.push_back({1'b0, 32'hFFFFFFFF});
`endif
        send(2'b11, 23'h7FFF00, 1'b1);
        sb_q.push_back({1'b0, 32'hFFFC1234});
        send(2'b10, 23'h412345, 1'b0);
        sb_q.push_back({1'b0, 32'h00003FAB});
        send(2'b11, 23'h3FAB00, 1'b0);
        idle(2);

        // Prefix beat, then data beat.
        send(2'b00, 23'h00BEEF, 1'b0);
        @(negedge clk);
        check("pfx_no_out_valid", {31'b0, out_valid}, 32'd0);
        check("pfx_pending_set", {31'b0, pfx_pending}, 32'd1);
        @(posedge clk); #1;
        sb_q.push_back({1'b1, 32'hBEEF1234});
        send(2'b01, 23'h001234, 1'b0);
        @(negedge clk);
        check("pfx_pending_clr", {31'b0, pfx_pending}, 32'd0);
        @(posedge clk); #1;

        // Prefix overwrite while HELD, then a sign-filled short field.
        send(2'b00, 23'h00AAAA, 1'b0);
        send(2'b00, 23'h7F1357, 1'b0);
        sb_q.push_back({1'b1, 32'h1357FFFF});
        send(2'b11, 23'h7FFF00, 1'b0);
        idle(2);

        // Backpressure: two beats offered while the consumer stalls.
        out_ready = 1'b0;
        sb_q.push_back({1'b0, 32'h00000011});
        send(2'b01, 23'h000011, 1'b0);
        in_valid = 1'b1; extendSel = 2'b01; inm = 23'h000022; zext = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold", extendRes, 32'h00000011);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb_q.push_back({1'b0, 32'h00000022});
        @(negedge clk);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(2);

        // Flush while HELD with a beat offered the same cycle.
        send(2'b00, 23'h00BEEF, 1'b0);
        flush = 1'b1; in_valid = 1'b1; extendSel = 2'b01; inm = 23'h000777;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_pfx_pending", {31'b0, pfx_pending}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        sb_q.push_back({1'b0, 32'h00000005});
        send(2'b01, 23'h000005, 1'b0);
        idle(2);

        // Reset with a stalled result in the output register.
        out_ready = 1'b0;
        send(2'b01, 23'h000123, 1'b0);
        @(negedge clk);
        check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        pulse_reset();
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_extendRes", extendRes, 32'd0);
        check("mid_rst_pfx_pending", {31'b0, pfx_pending}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset while a prefix is held.
        send(2'b00, 23'h00BEEF, 1'b0);
        @(negedge clk);
        check("pre_rst_pfx_pending", {31'b0, pfx_pending}, 32'd1);
        pulse_reset();
        check("held_rst_pfx_pending", {31'b0, pfx_pending}, 32'd0);
        @(posedge clk); #1;
        sb_q.push_back({1'b0, 32'h00000005});
        send(2'b01, 23'h000005, 1'b0);
        idle(4);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
